// File: rtl/reg_wb_arbiter.sv
// Round-robin writeback arbiter for the register bank write port, with busy scoreboard and flush drain.
// Optional same-cycle write forwarding ports are enabled by defining REG_WB_BYPASS_EN.
module reg_wb_arbiter #(
   parameter int DW      = 32,
   parameter int AW      = 4,
   parameter int PROT_HI = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   input  logic [AW-1:0]     req0_rd,
   input  logic [DW-1:0]     req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [AW-1:0]     req1_rd,
   input  logic [DW-1:0]     req1_data,
   output logic              req1_ready,
   input  logic              set_busy,
   input  logic [AW-1:0]     set_busy_rd,
   input  logic              flush_req,
   output logic              wr_en,
   output logic [AW-1:0]     wr_rd,
   output logic [DW-1:0]     wr_data,
   output logic [(2**AW)-1:0] busy_mask,
   output logic              issue_stall,
   output logic              flush_done
`ifdef REG_WB_BYPASS_EN
   ,
   input  logic [AW-1:0]     rs1,
   input  logic [AW-1:0]     rs2,
   output logic              fwd1_hit,
   output logic [DW-1:0]     fwd1_data,
   output logic              fwd2_hit,
   output logic [DW-1:0]     fwd2_data
`endif
);

   localparam int NR = 2**AW;

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   // Register 0 and PROT_HI are never written and never tracked as busy.
   function automatic logic is_prot(input logic [AW-1:0] rd);
      return (rd == {AW{1'b0}}) || (rd == AW'(PROT_HI));
   endfunction

   function automatic logic [NR-1:0] rd_bit(input logic [AW-1:0] rd);
      return {{(NR-1){1'b0}}, 1'b1} << rd;
   endfunction

   state_t          state_q, state_d;
   logic            prio_q, prio_d;
   logic            wr_en_q, wr_en_d;
   logic [AW-1:0]   wr_rd_q, wr_rd_d;
   logic [DW-1:0]   wr_data_q, wr_data_d;
   logic [NR-1:0]   busy_q, busy_d;
   logic            issue_stall_q, issue_stall_d;
   logic            flush_done_q, flush_done_d;

   logic            grant0_s, grant1_s, hs_s;
   logic [AW-1:0]   g_rd_s;
   logic [DW-1:0]   g_data_s;
   logic [NR-1:0]   set_vec_s, clr_vec_s;

   // Round-robin grant selection and the captured request.
   always_comb begin
      grant0_s = req0_valid & (~req1_valid | ~prio_q);
      grant1_s = req1_valid & (~req0_valid | prio_q);
      hs_s     = 1'b0;
      g_rd_s   = {AW{1'b0}};
      g_data_s = {DW{1'b0}};
      prio_d   = prio_q;
      if (grant0_s) begin
         hs_s     = 1'b1;
         g_rd_s   = req0_rd;
         g_data_s = req0_data;
         prio_d   = 1'b1;
      end else if (grant1_s) begin
         hs_s     = 1'b1;
         g_rd_s   = req1_rd;
         g_data_s = req1_data;
         prio_d   = 1'b0;
      end else begin
         hs_s     = 1'b0;
      end
   end

   // Write port, scoreboard and flush FSM next-state.
   always_comb begin
      wr_en_d      = hs_s & ~is_prot(g_rd_s);
      wr_rd_d      = wr_rd_q;
      wr_data_d    = wr_data_q;
      state_d      = state_q;
      flush_done_d = 1'b0;
      set_vec_s    = {NR{1'b0}};
      clr_vec_s    = {NR{1'b0}};

      if (wr_en_d) begin
         wr_rd_d   = g_rd_s;
         wr_data_d = g_data_s;
      end else begin
         wr_rd_d   = wr_rd_q;
         wr_data_d = wr_data_q;
      end

      if (hs_s) begin
         clr_vec_s = rd_bit(g_rd_s);
      end else begin
         clr_vec_s = {NR{1'b0}};
      end

      if ((state_q == ST_RUN) && set_busy && !is_prot(set_busy_rd)) begin
         set_vec_s = rd_bit(set_busy_rd);
      end else begin
         set_vec_s = {NR{1'b0}};
      end

      // Set is applied after clear so a same-cycle set on a retiring register wins.
      busy_d = (busy_q & ~clr_vec_s) | set_vec_s;

      case (state_q)
         ST_RUN: begin
            if (flush_req) begin
               state_d = ST_FLUSH;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_FLUSH: begin
            if ((busy_q == {NR{1'b0}}) && !req0_valid && !req1_valid) begin
               state_d      = ST_RUN;
               flush_done_d = 1'b1;
            end else begin
               state_d      = ST_FLUSH;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase

      issue_stall_d = (state_d == ST_FLUSH);
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_RUN;
         prio_q        <= 1'b0;
         wr_en_q       <= 1'b0;
         wr_rd_q       <= {AW{1'b0}};
         wr_data_q     <= {DW{1'b0}};
         busy_q        <= {NR{1'b0}};
         issue_stall_q <= 1'b0;
         flush_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         prio_q        <= prio_d;
         wr_en_q       <= wr_en_d;
         wr_rd_q       <= wr_rd_d;
         wr_data_q     <= wr_data_d;
         busy_q        <= busy_d;
         issue_stall_q <= issue_stall_d;
         flush_done_q  <= flush_done_d;
      end
   end

   assign req0_ready  = grant0_s;
   assign req1_ready  = grant1_s;
   assign wr_en       = wr_en_q;
   assign wr_rd       = wr_rd_q;
   assign wr_data     = wr_data_q;
   assign busy_mask   = busy_q;
   assign issue_stall = issue_stall_q;
   assign flush_done  = flush_done_q;

`ifdef REG_WB_BYPASS_EN
   // Forward the write being committed this cycle to the two read operands.
   always_comb begin
      fwd1_hit = wr_en_q & (wr_rd_q == rs1);
      fwd2_hit = wr_en_q & (wr_rd_q == rs2);
      if (fwd1_hit) begin
         fwd1_data = wr_data_q;
      end else begin
         fwd1_data = {DW{1'b0}};
      end
      if (fwd2_hit) begin
         fwd2_data = wr_data_q;
      end else begin
         fwd2_data = {DW{1'b0}};
      end
   end
`endif

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Shares the register bank's single write port between two writeback requesters: req0 (ALU writeback) and req1 (load return).
- Uses valid/ready handshakes and round-robin priority, and drives a registered write port into the bank.
- Keeps a 16-entry busy scoreboard of destination registers with writes still in flight, for hazard stall logic.
- Supports a FLUSH sequence that stalls issue until every in-flight write has been committed.

Parameters:
- DW, 32, data width of write data.
- AW, 4, register address width; the scoreboard has 2**AW entries.
- PROT_HI, 15, second protected register index; register 0 is always protected.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- req0_valid  in  1  ALU writeback request
- req0_rd  in  AW  ALU destination register
- req0_data  in  DW  ALU result
- req0_ready  out  1  ALU request accepted this cycle
- req1_valid  in  1  load-return request
- req1_rd  in  AW  load destination register
- req1_data  in  DW  load data
- req1_ready  out  1  load request accepted this cycle
- set_busy  in  1  issue stage marks a destination as pending
- set_busy_rd  in  AW  pending destination register
- flush_req  in  1  one-cycle pulse that starts a drain
- wr_en  out  1  bank write enable (registered)
- wr_rd  out  AW  bank write address (registered)
- wr_data  out  DW  bank write data (registered)
- busy_mask  out  2**AW  scoreboard; bit n=1 means a write to register n is pending
- issue_stall  out  1  high while in FLUSH
- flush_done  out  1  one-cycle pulse when the drain completes

Behaviour:
- Reset (rst_n=0 at a rising edge of clk):
  - wr_en=0, wr_rd=0, wr_data=0, busy_mask=0, issue_stall=0, flush_done=0.
  - prio=0, state=RUN.
  - Reset mid-flush abandons the flush; flush_done is not pulsed.
- Ready generation (combinational):
  - req0_ready = req0_valid & (~req1_valid | prio==0).
  - req1_ready = req1_valid & (~req0_valid | prio==1).
  - At most one ready is high per cycle. Ready never asserts without its own valid.
  - A requester holds valid, rd and data stable until it sees ready.
- Priority:
  - After any grant, prio points to the non-granted requester: grant 0 sets prio=1, grant 1 sets prio=0.
  - With no grant, prio holds its value.
- Write port:
  - Latency is 1 cycle. The cycle after a handshake, wr_en=1 and wr_rd/wr_data hold the captured values.
  - With no handshake, wr_en=0 and wr_rd/wr_data hold their previous values.
- Protected registers:
  - A handshake with rd==0 or rd==PROT_HI is still accepted (ready=1), but wr_en stays 0.
- Scoreboard:
  - set_busy in RUN sets busy_mask[set_busy_rd], unless rd is 0 or PROT_HI.
  - A granted request clears busy_mask[rd] in the same edge as the handshake, not at the wr_en cycle.
  - If set and clear hit the same rd in the same cycle, set wins.
  - Setting a bit that is already set leaves it set; the scoreboard does not count writers.
  - A clear for a bit that is not set is a no-op.
- FSM:
  - RUN:
    - issue_stall=0.
    - flush_req moves the FSM to FLUSH on the next edge.
  - FLUSH:
    - issue_stall=1.
    - set_busy is ignored.
    - Arbitration continues normally.
    - When busy_mask==0 and both valids are 0 at a rising edge, the FSM moves to RUN and flush_done=1 for exactly one cycle.
    - flush_req received while already in FLUSH is ignored.
  - A flush_req with busy_mask already 0 gives: FLUSH for 1 cycle, then RUN with the flush_done pulse.

Optional Feature:
- Macro: REG_WB_BYPASS_EN.
- When defined, the block adds ports:
  - rs1  in  AW
  - rs2  in  AW
  - fwd1_hit  out  1
  - fwd1_data  out  DW
  - fwd2_hit  out  1
  - fwd2_data  out  DW
- fwdN_hit = wr_en & (wr_rd==rsN), evaluated combinationally.
- fwdN_data = wr_data when fwdN_hit is 1, else 0.
- This covers the cycle in which a committed write is not yet visible to bank reads.
- When not defined, these ports and their logic are absent, and the behaviour of all other ports is identical.

Test Plan:
- Reset, then req0_valid=1, rd=3, data=0x15D. Required: req0_ready=1 the same cycle; next cycle wr_en=1, wr_rd=3, wr_data=0x15D; the following cycle wr_en=0.
- req0 and req1 both held valid (rd 4/5) for 4 cycles from prio=0. Required: grants alternate 0,1,0,1; wr_rd sequence is 4,5,4,5; no cycle has both readys high.
- req1 with rd=0, then with rd=15. Required: req1_ready=1 both times, wr_en stays 0, busy_mask is unchanged.
- set_busy rd=7, then req0 rd=7 in the same cycle as a new set_busy rd=7. Required: busy_mask[7] remains 1 (set wins). A later req0 rd=7 with no set_busy clears bit 7.
- busy_mask=0x0060 (regs 5 and 6), then flush_req. Required: issue_stall=1 the next cycle and set_busy rd=9 is ignored; after the writes to 5 and 6 are granted, flush_done pulses for 1 cycle, then issue_stall=0.
- Reset asserted during FLUSH. Required: all outputs 0 next cycle, state=RUN, no flush_done pulse.
- REG_WB_BYPASS_EN: with rs1=3, rs2=8 in the wr_en cycle of the first scenario. Required: fwd1_hit=1 with fwd1_data=0x15D; fwd2_hit=0 with fwd2_data=0.
